// File: rtl/button_encoder_if.sv
// Command-side bundle of the button encoder: raw push-buttons in, command code
// and debounced levels out. The encoder is the slave; the panel/test side is the master.
interface button_encoder_if;
    logic       btn_rst;
    logic       btn_stop;
    logic       btn_start;
    logic [1:0] cmd;
    logic [2:0] deb;

    modport master (
        output btn_rst, btn_stop, btn_start,
        input  cmd, deb
    );

    modport slave (
        input  btn_rst, btn_stop, btn_start,
        output cmd, deb
    );
endinterface

// File: rtl/button_encoder.sv
// Synchronises and debounces the reset/stop/start push-buttons and encodes them
// into the registered 2-bit command code consumed by the chronometer control FSM.
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int CNT_W           = 15
) (
    input  logic            clk,
    input  logic            clr,
    button_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_RST   = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_START = 2'b11
    } cmd_e;

    // Channel index inside the packed per-button vectors; matches the deb bit order.
    localparam int CH_RST   = 0;
    localparam int CH_STOP  = 1;
    localparam int CH_START = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       d;
    logic [2:0]       d_next;
    logic [CNT_W-1:0] cnt      [3];
    logic [CNT_W-1:0] cnt_next [3];
    logic             d_rst_q;
    logic             rst_pulse;
    cmd_e             cmd_q;
    cmd_e             cmd_next;

    assign raw = {bus.btn_start, bus.btn_stop, bus.btn_rst};

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive
    // samples disagreeing with the current debounced level; any agreement restarts it.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no path leaves
        // it unassigned -- otherwise synthesis infers a latch.
        d_next = d;
        for (int i = 0; i < 3; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != d[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    d_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the rising edge of the debounced reset is a command; holding it is not.
    assign rst_pulse = d[CH_RST] & ~d_rst_q;

    always_comb begin
        cmd_next = CMD_IDLE;
        if (rst_pulse) begin
            cmd_next = CMD_RST;
        end else if (d[CH_STOP]) begin
            cmd_next = CMD_STOP;
        end else if (d[CH_START]) begin
            cmd_next = CMD_START;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (clr) begin
            s1      <= '0;
            s2      <= '0;
            d       <= '0;
            d_rst_q <= 1'b0;
            cmd_q   <= CMD_IDLE;
            // NOTE: cnt is three plain registers rather than a RAM, so it is reset
            // like any other flop; a partial count must not survive clr.
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            d       <= d_next;
            d_rst_q <= d[CH_RST];
            cmd_q   <= cmd_next;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign bus.cmd = cmd_q;
    assign bus.deb = d;
endmodule

// File: doc/button_encoder.md
# button_encoder

Front-end command source for the chronometer control FSM. It takes three raw, asynchronous, bouncing push-buttons (reset, stop, start) and synchronises and debounces each one. It then encodes them onto the 2-bit command bus that the control FSM samples on every `clk` edge. The block runs on the same 2.5 MHz system clock and drives the FSM's `in[1:0]` input directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 25000: consecutive stable cycles needed to accept a level change (10 ms at 2.5 MHz). Legal range ≥ 2.
- `CNT_W`, default 15: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` input 1: system clock, rising-edge active.
- `clr` input 1: reset, synchronous, active-high.
- `btn_rst` input 1: raw reset button, active-high, asynchronous to `clk`.
- `btn_stop` input 1: raw stop button, active-high, asynchronous.
- `btn_start` input 1: raw start button, active-high, asynchronous.
- `cmd` output 2: registered command code to the control FSM.
- `deb` output 3: debounced levels {start, stop, rst}, registered, for debug and LEDs.

## Operation
- Each button has its own channel:
  - 2-flop synchroniser `s1 -> s2`.
  - Debounce counter `cnt` of width CNT_W.
  - Debounced level `d`.
- Debounce rule, evaluated per channel every cycle:
  - `s2 == d`: `cnt <= 0`.
  - `s2 != d` and `cnt == DEBOUNCE_CYCLES-1`: `d <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - Any bounce shorter than DEBOUNCE_CYCLES cycles therefore restarts the count and never changes `d`.
  - The same rule applies to both press and release.
- Reset edge detect: `d_rst_q` holds `d_rst` delayed by one cycle. `rst_pulse = d_rst & ~d_rst_q`.
- Command encoding (registered into `cmd`), fixed priority, first match wins:
  - `rst_pulse` → `cmd = 2'b01`, for exactly one cycle per press.
  - `d_stop` → `cmd = 2'b10`, held for as long as the debounced stop is high.
  - `d_start` → `cmd = 2'b11`, held for as long as the debounced start is high.
  - Otherwise → `cmd = 2'b00`.
- Simultaneous presses:
  - Reset pulse overrides stop and start for its single cycle. Then `cmd` falls back to the stop/start level encoding.
  - Stop overrides start while both are held.
- Holding the reset button generates only one `01` pulse. A new pulse requires a debounced release followed by a debounced press.
- `deb` = {`d_start`, `d_stop`, `d_rst`}.
- Counter arithmetic is unsigned. It never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

## Timing
- Reset (`clr`=1 at a rising edge) clears all of the following to 0 on that edge: `s1`, `s2`, `cnt`, `d`, `d_rst_q`, `cmd`, `deb`. Outputs after reset are `cmd = 2'b00` and `deb = 3'b000`.
- `clr` has priority over every other update.
- Reset mid-debounce discards the partial count.
- A button still held when `clr` deasserts is treated as a new press. It appears after the full latency, so a held reset button yields one `01` pulse after reset.
- Latency: take edge 0 as the first edge that samples the raw level into `s1`.
  - `s2` follows at edge 1.
  - `d` (and `deb`) changes at edge D+1, where D = DEBOUNCE_CYCLES.
  - `cmd` changes at edge D+2.
- A clean release has the same latency: D+2 edges from the first sample of the low level to `cmd` leaving the code.
- Minimum `01` pulse width is 1 cycle and is also the maximum.
- `cmd` has no combinational path from any input.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset:
   - Stimulus: all buttons high, `clr`=1 for 3 cycles.
   - Check during reset: `cmd`=00, `deb`=000.
   - Check after release: `cmd` goes 01 for 1 cycle, then 10 while the buttons stay high, at edge 6 after `clr` low.
2. Clean start press:
   - Stimulus: `btn_start` high for 20 cycles.
   - Check: `cmd`=11 from edge 6 after the press until 6 edges after release.
   - Check: `deb[2]` is high over edges 5 through 5 after release.
3. Bounce rejection:
   - Stimulus: `btn_stop` toggles high 3 cycles / low 1 cycle, repeated 5 times, then stays low.
   - Check: `cmd` stays 00 and `deb` stays 000 throughout.
4. Reset pulse:
   - Stimulus: `btn_rst` held for 50 cycles.
   - Check: `cmd`=01 for exactly one cycle (edge 6), then 00.
   - Stimulus: release, then press again.
   - Check: second single `01` pulse.
5. Priority:
   - Stimulus: `btn_start` held, then `btn_stop` pressed.
   - Check: `cmd` 11 → 10, then returns to 11 after stop's debounced release.
   - Stimulus: press `btn_rst` during this.
   - Check: one cycle of 01, then back to 10.
6. Mid-debounce reset:
   - Stimulus: `btn_start` high, `clr` pulsed 2 cycles after `s2` goes high, button kept high.
   - Check: `cmd`=00 through reset, then 11 exactly 6 edges after `clr` deasserts.
